// File: rtl/regfile_sb_pkg.sv
// Shared types for the regfile_sb register file and its load scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a; decode stalls on rd_busy_o, no handshake.
package regfile_sb_pkg;

    // Default configuration: 32 registers, 5-bit addresses.
    localparam int REGFILE_DEPTH = 32;

    typedef logic [4:0] regaddr_t;  // register address
    typedef logic [5:0] size_t;     // 0..REGFILE_DEPTH

    // Reason err_o was raised in a given cycle.
    typedef enum logic [1:0] {
        RF_ERR_NONE       = 2'd0,
        RF_ERR_ISSUE_BUSY = 2'd1,   // load issued to a register with a load outstanding
        RF_ERR_RET_IDLE   = 2'd2    // load returned to a register with no load outstanding
    } rf_err_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Operand read, ALU writeback and load issue/return bundle for regfile_sb.
// Latency: n/a (wires only).
// Backpressure: none; the master stalls itself on rd_busy_o.
interface regfile_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2
);
    logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr_i;
    logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_o;
    logic [READ_PORTS-1:0]            rd_busy_o;
    logic                             wr_en_i;
    logic [ADDR_WIDTH-1:0]            wr_addr_i;
    logic [DATA_WIDTH-1:0]            wr_data_i;
    logic                             ld_issue_i;
    logic [ADDR_WIDTH-1:0]            ld_issue_addr_i;
    logic                             ld_wr_en_i;
    logic [ADDR_WIDTH-1:0]            ld_wr_addr_i;
    logic [DATA_WIDTH-1:0]            ld_wr_data_i;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               ld_issue_i, ld_issue_addr_i, ld_wr_en_i, ld_wr_addr_i, ld_wr_data_i,
        input  rd_data_o, rd_busy_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               ld_issue_i, ld_issue_addr_i, ld_wr_en_i, ld_wr_addr_i, ld_wr_data_i,
        output rd_data_o, rd_busy_o
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register load-outstanding bits, pending-load counter and sticky protocol error.
// Latency: updates land at the clock edge; outputs are the registered state.
// Backpressure: none; issue/return are accepted every cycle, misuse raises err_o.
import regfile_sb_pkg::*;

module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic                  ret_i,
    input  logic [ADDR_WIDTH-1:0] ret_addr_i,
    output logic [DEPTH-1:0]      busy_o,
    output logic [ADDR_WIDTH:0]   pending_o,
    output logic                  err_o
);
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [ADDR_WIDTH:0] pending_q, pending_d;
    logic                err_q, err_d;
    logic                issue_v, ret_v, same_addr, inc, dec;
    rf_err_e             cause;

    // Next busy/count/error state; register 0 is never tracked.
    always_comb begin
        issue_v   = issue_i && (issue_addr_i != '0);
        ret_v     = ret_i && (ret_addr_i != '0);
        same_addr = issue_v && ret_v && (issue_addr_i == ret_addr_i);
        // Counter follows 0->1 and 1->0 transitions of busy bits. A return
        // paired with a new issue on the same register leaves the bit set.
        inc       = issue_v && !busy_q[issue_addr_i];
        dec       = ret_v && busy_q[ret_addr_i] && !same_addr;

        busy_d = busy_q;
        if (ret_v)   busy_d[ret_addr_i]   = 1'b0;
        if (issue_v) busy_d[issue_addr_i] = 1'b1;

        pending_d = pending_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);

        cause = RF_ERR_NONE;
        if (ret_v && !busy_q[ret_addr_i])
            cause = RF_ERR_RET_IDLE;
        else if (issue_v && busy_q[issue_addr_i] && !same_addr)
            cause = RF_ERR_ISSUE_BUSY;
        err_d = err_q || (cause != RF_ERR_NONE);
    end

    // Scoreboard state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // The counter must always equal the number of set busy bits.
    always_ff @(posedge clk) begin
        if (!reset_i) assert (int'(pending_q) == $countones(busy_q));
    end

    assign busy_o    = busy_q;
    assign pending_o = pending_q;
    assign err_o     = err_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with ALU (A) and load (B) writeback plus load scoreboard.
// Latency: reads combinational; writes visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; rd_busy_o tells decode to stall on an outstanding load.
import regfile_sb_pkg::*;

module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2
) (
    input  logic                clk,
    input  logic                reset_i,
    regfile_sb_if.slave         rf_bus,
    output logic [ADDR_WIDTH:0] pending_o,
    output logic                err_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy;

    regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_sb (
        .clk          (clk),
        .reset_i      (reset_i),
        .issue_i      (rf_bus.ld_issue_i),
        .issue_addr_i (rf_bus.ld_issue_addr_i),
        .ret_i        (rf_bus.ld_wr_en_i),
        .ret_addr_i   (rf_bus.ld_wr_addr_i),
        .busy_o       (busy),
        .pending_o    (pending_o),
        .err_o        (err_o)
    );

    // Register array; port B is written last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (rf_bus.wr_en_i && (rf_bus.wr_addr_i != '0))
                mem_q[rf_bus.wr_addr_i] <= rf_bus.wr_data_i;
            if (rf_bus.ld_wr_en_i && (rf_bus.ld_wr_addr_i != '0))
                mem_q[rf_bus.ld_wr_addr_i] <= rf_bus.ld_wr_data_i;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;

        assign addr = rf_bus.rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REGFILE_BYPASS_EN
        // Read mux with same-cycle forwarding of in-flight writes (B over A).
        always_comb begin
            data = mem_q[addr];
            bsy  = busy[addr];
            if (!reset_i && (addr != '0)) begin
                if (rf_bus.ld_wr_en_i && (rf_bus.ld_wr_addr_i == addr)) begin
                    data = rf_bus.ld_wr_data_i;
                    if (!(rf_bus.ld_issue_i && (rf_bus.ld_issue_addr_i == addr)))
                        bsy = 1'b0;
                end else if (rf_bus.wr_en_i && (rf_bus.wr_addr_i == addr)) begin
                    data = rf_bus.wr_data_i;
                end
            end
        end
`else
        // Read mux straight from registered state; r0 is never written so reads 0.
        always_comb begin
            data = mem_q[addr];
            bsy  = busy[addr];
        end
`endif

        assign rf_bus.rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rf_bus.rd_busy_o[k] = bsy;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with two write ports and a load scoreboard; successor to the fixed 2R1W CPU register file. It sits between decode and writeback. It provides combinational operand reads, an ALU writeback port, and a delayed memory-load writeback port. A per-register busy bit tracks outstanding loads so decode can stall on RAW hazards.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
- READ_PORTS, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_i  in  1  reset, asynchronous, active-high
- rd_addr_i  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data_o  out  READ_PORTS*DATA_WIDTH  packed read data, same packing
- rd_busy_o  out  READ_PORTS  addressed register has a load outstanding
- wr_en_i  in  1  ALU writeback enable (port A)
- wr_addr_i  in  ADDR_WIDTH  port A address
- wr_data_i  in  DATA_WIDTH  port A data
- ld_issue_i  in  1  load issued; marks ld_issue_addr_i busy
- ld_issue_addr_i  in  ADDR_WIDTH  destination of the issued load
- ld_wr_en_i  in  1  load data return (port B); clears busy
- ld_wr_addr_i  in  ADDR_WIDTH  port B address
- ld_wr_data_i  in  DATA_WIDTH  port B data
- pending_o  out  ADDR_WIDTH+1  number of busy registers
- err_o  out  1  sticky scoreboard protocol error

## Operation
- Register 0 always reads 0. Writes and issues to address 0 are ignored: no busy bit, no count change, no error.
- Reads are combinational from the array.
- Same-cycle write collision (wr_en_i and ld_wr_en_i to the same address): port B data is stored.
- Busy bit set by ld_issue_i. Busy bit cleared by ld_wr_en_i.
- Issue and return to the same address in the same cycle: the bit stays set, because it now marks the new load, and pending_o is unchanged.
- pending_o equals the popcount of busy bits. It is maintained as a counter: +1 on a 0→1 transition, −1 on a 1→0 transition. A simultaneous set on one address and clear on another leaves the count unchanged.
- err_o is set on either of these, and clears only on reset:
  - issue to an already-busy register (busy stays set, count unchanged);
  - return to a non-busy register (data is still written, count unchanged).
- Port A writes to a busy register are accepted. The busy bit is unaffected, so the later load return overwrites (WAW is the issuer's responsibility).

## Timing
- Write latency: data is visible on rd_data_o the cycle after the write edge (without bypass).
- Busy and count updates take effect at the edge; rd_busy_o reflects the registered bits combinationally.
- Reset asserted at any time, including mid-load: asynchronously clears all registers to 0, all busy bits, pending_o = 0 and err_o = 0. While reset is held, rd_data_o = 0 and rd_busy_o = 0.
- Outstanding loads whose return arrives after reset deassertion are treated as returns to non-busy registers: the data is written and err_o is set.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read of an address currently being written returns the incoming write data in the same cycle (port B over port A, address 0 excluded);
  - rd_busy_o is forced low for an address being returned by ld_wr_en_i that cycle, unless ld_issue_i targets the same address in that cycle.
- REGFILE_BYPASS_EN undefined: reads and busy are purely from registered state, with one-cycle write-to-read latency.

## Structure
- Package codes: reuse regaddr_t and size_t for the default configuration. Add REGFILE_DEPTH and a regfile error-cause enum for assertions.
- Sub-module regfile_scoreboard: busy vector, pending counter, err_o and the set/clear rules. The top-level holds the array, read muxes and bypass.

## Test plan
- Reset → every rd_data_o = 0, rd_busy_o = 0, pending_o = 0, err_o = 0. Write r5 = 0xDEADBEEF → next cycle reads 0xDEADBEEF on all ports.
- Port A write 0x1234 to r0 → r0 reads 0. Issue load to r0 → pending_o stays 0, err_o stays 0.
- Issue r3 and r7 on consecutive cycles → pending_o = 2, busy high on r3/r7 reads. Return r3 = 0xAA → pending_o = 1, r3 reads 0xAA.
- Same cycle: port A r9 = 1 and port B r9 = 2 → r9 reads 2. With REGFILE_BYPASS_EN, 2 is read in the write cycle.
- Issue r4 twice → err_o = 1, pending_o = 1. Return to idle r6 → data written, err_o stays 1.
- Issue r8, assert reset_i mid-cycle between edges → outputs clear immediately. After deassert, return r8 → err_o = 1, pending_o = 0.
